// File: rtl/wb_write_arbiter.sv
// Register-file writeback arbiter: the main pipeline has priority, while MDU results queue in a
// FIFO and are guaranteed a slot within a bounded number of cycles.
module wb_write_arbiter #(
  parameter int unsigned MDU_DEPTH    = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         pipe_valid,
  input  logic [4:0]                   pipe_rd,
  input  logic [31:0]                  pipe_data,
  output logic                         pipe_ready,
  input  logic                         mdu_valid,
  input  logic [4:0]                   mdu_rd,
  input  logic [31:0]                  mdu_data,
  output logic                         mdu_ready,
  output logic                         reg_write,
  output logic [4:0]                   rd,
  output logic [31:0]                  write_data,
  output logic [31:0]                  busy_mask,
  output logic [$clog2(MDU_DEPTH):0]   fifo_count
);

  localparam int unsigned PW = $clog2(MDU_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [PW-1:0]        r_wptr, r_rptr;
  logic [CW-1:0]        r_count;
  logic [SW-1:0]        r_starve;
  logic [MDU_DEPTH-1:0] r_vld;
  logic [4:0]           r_mem_rd   [MDU_DEPTH];
  logic [31:0]          r_mem_data [MDU_DEPTH];
  logic                 r_reg_write;
  logic [4:0]           r_rd;
  logic [31:0]          r_write_data;

  logic [PW-1:0]        w_wptr_nxt, w_rptr_nxt;
  logic [CW-1:0]        w_count_nxt;
  logic [SW-1:0]        w_starve_nxt;
  logic [MDU_DEPTH-1:0] w_vld_nxt;
  logic                 w_reg_write_nxt;
  logic [4:0]           w_rd_nxt;
  logic [31:0]          w_write_data_nxt;
  logic                 w_pipe_ready, w_mdu_ready, w_empty;
  logic                 w_pipe_win, w_deq, w_enq;
  logic [31:0]          w_busy;

  // Handshake decode; readies depend on registered state only
  assign w_pipe_ready = (r_starve != SW'(STARVE_LIMIT));
  assign w_mdu_ready  = (r_count < CW'(MDU_DEPTH));
  assign w_empty      = (r_count == '0);
  // A zero-destination pipeline transfer is absorbed without claiming the write port
  assign w_pipe_win   = pipe_valid & w_pipe_ready & (pipe_rd != 5'd0);
  assign w_deq        = ~w_pipe_win & ~w_empty;
  assign w_enq        = mdu_valid & w_mdu_ready & (mdu_rd != 5'd0);

  // Next-state for FIFO bookkeeping, starvation counter and the write port
  always_comb begin
    w_wptr_nxt       = r_wptr;
    w_rptr_nxt       = r_rptr;
    w_count_nxt      = r_count;
    w_starve_nxt     = r_starve;
    w_vld_nxt        = r_vld;
    w_reg_write_nxt  = 1'b0;
    w_rd_nxt         = r_rd;
    w_write_data_nxt = r_write_data;

    if (w_deq) begin
      w_vld_nxt[r_rptr] = 1'b0;
      w_rptr_nxt        = r_rptr + PW'(1);
    end
    if (w_enq) begin
      w_vld_nxt[r_wptr] = 1'b1;
      w_wptr_nxt        = r_wptr + PW'(1);
    end
    case ({w_enq, w_deq})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase

    if (w_empty || w_deq)
      w_starve_nxt = '0;
    else if (w_pipe_win)
      w_starve_nxt = r_starve + SW'(1);

    if (w_pipe_win) begin
      w_reg_write_nxt  = 1'b1;
      w_rd_nxt         = pipe_rd;
      w_write_data_nxt = pipe_data;
    end else if (w_deq) begin
      w_reg_write_nxt  = 1'b1;
      w_rd_nxt         = r_mem_rd[r_rptr];
      w_write_data_nxt = r_mem_data[r_rptr];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_starve     <= '0;
      r_vld        <= '0;
      r_reg_write  <= 1'b0;
      r_rd         <= '0;
      r_write_data <= '0;
    end else begin
      r_wptr       <= w_wptr_nxt;
      r_rptr       <= w_rptr_nxt;
      r_count      <= w_count_nxt;
      r_starve     <= w_starve_nxt;
      r_vld        <= w_vld_nxt;
      r_reg_write  <= w_reg_write_nxt;
      r_rd         <= w_rd_nxt;
      r_write_data <= w_write_data_nxt;
    end
  end

  // Payload storage; entry validity is tracked separately, so no reset is needed
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem_rd[r_wptr]   <= mdu_rd;
      r_mem_data[r_wptr] <= mdu_data;
    end
  end

  always_comb begin
    w_busy = '0;
    for (int i = 0; i < int'(MDU_DEPTH); i++) begin
      if (r_vld[i]) w_busy = w_busy | (32'(1) << r_mem_rd[i]);
    end
    w_busy[0] = 1'b0;
  end

  assign pipe_ready = w_pipe_ready;
  assign mdu_ready  = w_mdu_ready;
  assign reg_write  = r_reg_write;
  assign rd         = r_rd;
  assign write_data = r_write_data;
  assign busy_mask  = w_busy;
  assign fifo_count = r_count;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed and random stimulus for wb_write_arbiter, checked against a behavioural queue model
// through a writeback scoreboard.
module tb_wb_write_arbiter;

  localparam int DEPTH  = 4;
  localparam int STARVE = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic        pipe_valid, mdu_valid;
  logic [4:0]  pipe_rd, mdu_rd;
  logic [31:0] pipe_data, mdu_data;
  logic        pipe_ready, mdu_ready, reg_write;
  logic [4:0]  rd;
  logic [31:0] write_data, busy_mask;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          we;
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t         sb[$];
  logic [4:0]  m_rd[$];
  logic [31:0] m_data[$];
  int          m_starve = 0;

  always #5 clk = ~clk;

  wb_write_arbiter #(.MDU_DEPTH(DEPTH), .STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .rstn(rstn),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data), .pipe_ready(pipe_ready),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .reg_write(reg_write), .rd(rd), .write_data(write_data),
    .busy_mask(busy_mask), .fifo_count(fifo_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] b = '0;
    foreach (m_rd[i]) b[m_rd[i]] = 1'b1;
    b[0] = 1'b0;
    return b;
  endfunction

  // One clock cycle: drive inputs, predict, advance, compare
  task automatic cyc(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                     input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    bit  epr, emr, win, deq, enq;
    int  sz;
    wr_t w;
    pipe_valid = pv; pipe_rd = prd; pipe_data = pd;
    mdu_valid  = mv; mdu_rd  = mrd; mdu_data  = md;
    sz  = m_rd.size();
    epr = (m_starve != STARVE);
    emr = (sz < DEPTH);
    #0;
    chk("pipe_ready", 32'(pipe_ready), 32'(epr));
    chk("mdu_ready", 32'(mdu_ready), 32'(emr));
    win = pv && epr && (prd != 5'd0);
    deq = !win && (sz > 0);
    enq = mv && emr && (mrd != 5'd0);
    w.we = win || deq;
    w.rd = '0;
    w.data = '0;
    if (win) begin
      w.rd = prd; w.data = pd;
    end else if (deq) begin
      w.rd = m_rd.pop_front(); w.data = m_data.pop_front();
    end
    if (sz == 0 || deq) m_starve = 0;
    else if (win) m_starve++;
    if (enq) begin
      m_rd.push_back(mrd); m_data.push_back(md);
    end
    sb.push_back(w);
    @(posedge clk);
    #1;
    w = sb.pop_front();
    chk("reg_write", 32'(reg_write), 32'(w.we));
    if (w.we) begin
      chk("rd", 32'(rd), 32'(w.rd));
      chk("write_data", write_data, w.data);
    end
    chk("fifo_count", 32'(fifo_count), 32'(m_rd.size()));
    chk("busy_mask", busy_mask, model_busy());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic chk_reset_state();
    chk("rst_reg_write", 32'(reg_write), 32'd0);
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_write_data", write_data, 32'd0);
    chk("rst_busy_mask", busy_mask, 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_pipe_ready", 32'(pipe_ready), 32'd1);
    chk("rst_mdu_ready", 32'(mdu_ready), 32'd1);
  endtask

  initial begin
    // Reset with live requests that must not be recorded
    rstn = 1'b0;
    pipe_valid = 1'b1; pipe_rd = 5'd7; pipe_data = 32'h1234_5678;
    mdu_valid  = 1'b1; mdu_rd  = 5'd8; mdu_data  = 32'h8765_4321;
    #1;
    chk_reset_state();
    @(posedge clk);
    @(negedge clk);
    chk_reset_state();
    rstn = 1'b1;

    // Pipeline-only write on the first edge after release
    cyc(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);

    // Fill FIFO while pipeline holds the port
    cyc(1'b1, 5'd20, 32'hA000_0020, 1'b1, 5'd1, 32'hB000_0001);
    cyc(1'b1, 5'd21, 32'hA000_0021, 1'b1, 5'd2, 32'hB000_0002);
    cyc(1'b1, 5'd22, 32'hA000_0022, 1'b1, 5'd3, 32'hB000_0003);
    cyc(1'b1, 5'd23, 32'hA000_0023, 1'b1, 5'd4, 32'hB000_0004);
    // Full with dequeue: no enqueue this cycle, ready returns next cycle
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hB000_0005);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hB000_0005);
    idle(5);

    // Starvation: pipeline valid continuously while rd=9 waits
    cyc(1'b1, 5'd10, 32'hC000_0000, 1'b1, 5'd9, 32'h9999_9999);
    for (int i = 1; i <= 10; i++)
      cyc(1'b1, 5'(10 + i), 32'hC000_0000 + 32'(i), 1'b0, 5'd0, 32'd0);
    idle(1);

    // Zero destination on the pipeline lets the FIFO head through
    cyc(1'b1, 5'd11, 32'hD000_0011, 1'b1, 5'd3, 32'h3333_3333);
    cyc(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0);
    idle(1);

    // Zero destination on the MDU completes the handshake only
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h0BAD_0BAD);
    idle(1);

    // Reset mid-operation with three entries queued
    cyc(1'b1, 5'd12, 32'hE000_0012, 1'b1, 5'd6, 32'h6666_6666);
    cyc(1'b1, 5'd13, 32'hE000_0013, 1'b1, 5'd7, 32'h7777_7777);
    cyc(1'b1, 5'd14, 32'hE000_0014, 1'b1, 5'd8, 32'h8888_8888);
    chk("pre_rst_count", 32'(fifo_count), 32'd3);
    #2;
    rstn = 1'b0;
    #1;
    chk_reset_state();
    m_rd.delete(); m_data.delete(); m_starve = 0;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    idle(4);

    // Random traffic
    for (int i = 0; i < 200; i++)
      cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 32'($urandom),
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 32'($urandom));
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
WB_WRITE_ARBITER -- requirements
Module: wb_write_arbiter

Interface
REQ-001 SHALL have parameter MDU_DEPTH, default 4: MDU result FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter STARVE_LIMIT, default 8: consecutive pipe-priority cycles tolerated while the FIFO holds data.
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port rstn  in  1  reset; one clock, asynchronous, active-low.
REQ-005 SHALL have port pipe_valid  in  1  main-pipeline writeback request.
REQ-006 SHALL have port pipe_rd  in  5  pipeline destination register.
REQ-007 SHALL have port pipe_data  in  32  pipeline result.
REQ-008 SHALL have port pipe_ready  out  1  pipeline request accepted this cycle.
REQ-009 SHALL have port mdu_valid  in  1  multi-cycle unit result request.
REQ-010 SHALL have port mdu_rd  in  5  MDU destination register.
REQ-011 SHALL have port mdu_data  in  32  MDU result.
REQ-012 SHALL have port mdu_ready  out  1  FIFO can accept an entry.
REQ-013 SHALL have port reg_write  out  1  register-file write enable.
REQ-014 SHALL have port rd  out  5  register-file write address.
REQ-015 SHALL have port write_data  out  32  register-file write data.
REQ-016 SHALL have port busy_mask  out  32  bit i set while a FIFO entry targets register i.
REQ-017 SHALL have port fifo_count  out  clog2(MDU_DEPTH)+1  FIFO occupancy.

Function
REQ-018 SHALL issue at most one register-file write per cycle; reg_write/rd/write_data registered, one cycle after acceptance/dequeue.
REQ-019 Pipeline transfer SHALL occur when pipe_valid & pipe_ready; MDU enqueue when mdu_valid & mdu_ready.
REQ-020 mdu_ready SHALL equal (fifo_count < MDU_DEPTH), from registered count only; no enqueue when full even with simultaneous dequeue.
REQ-021 Priority: pipeline wins when pipe_ready=1 and pipe_valid=1; otherwise FIFO head dequeued and written if FIFO non-empty.
REQ-022 Starvation counter SHALL increment each cycle pipeline wins while FIFO non-empty, clear when FIFO empty or head dequeued.
REQ-023 When counter equals STARVE_LIMIT, pipe_ready SHALL be 0 for exactly that cycle, head dequeued, counter cleared; otherwise pipe_ready=1.
REQ-024 pipe_rd=0 transfers SHALL be accepted with no write (reg_write=0 next cycle); cycle not counted as pipeline win, head MAY dequeue same cycle.
REQ-025 mdu_rd=0 SHALL be accepted (handshake completes) but not enqueued.
REQ-026 FIFO SHALL retire strictly in acceptance order; read/write pointers wrap modulo MDU_DEPTH.
REQ-027 busy_mask SHALL be combinational OR of decoded rd over valid FIFO entries; bit 0 always 0; bit clears in cycle after entry's dequeue.
REQ-028 Simultaneous enqueue and dequeue SHALL leave fifo_count unchanged.
REQ-029 Cross-source ordering to same rd is not enforced here; hazard logic uses busy_mask.

Reset
REQ-030 On rstn low, asynchronously: reg_write=0, rd=0, write_data=0, FIFO emptied (pointers, count=0), busy_mask=0, starvation counter=0.
REQ-031 During reset pipe_ready=1 and mdu_ready=1 SHALL be driven but no transfer is recorded; entries accepted before reset mid-operation are discarded.
REQ-032 First transfer SHALL be possible on first rising edge after rstn deasserts.

Verification
REQ-033 Pipe only: pipe_valid=1, pipe_rd=5, pipe_data=0xDEADBEEF -> next cycle reg_write=1, rd=5, write_data=0xDEADBEEF.
REQ-034 MDU fill: 4 enqueues rd=1..4 with pipe idle, then mdu_valid -> mdu_ready=0 only if FIFO full; writes rd=1..4 in order, busy_mask bits clear in turn.
REQ-035 Starvation: FIFO holds rd=9, pipe_valid=1 continuously -> pipeline writes 8 cycles, cycle 9 pipe_ready=0, rd=9 written following cycle.
REQ-036 Zero register: pipe_rd=0 while FIFO holds rd=3 -> no write for rd=0, rd=3 written next cycle.
REQ-037 Reset mid-operation: FIFO count=3, rstn low -> fifo_count=0, busy_mask=0, reg_write=0 immediately, no stale writes after release.
REQ-038 Full + dequeue: FIFO full, pipe idle, mdu_valid=1 -> no enqueue that cycle, count 4->3, mdu_ready=1 next cycle.
